sonar_ping_qualifier: RTL
=========================

Name: sonar_ping_qualifier

Overview:
Front-end stage of the SONAR path. It takes NUM_CH raw hydrophone comparator outputs and synchronises each one. It then glitch-filters each channel and enforces a per-channel holdoff after every qualified ping. The outputs are the held toggle requests and the periodic enable strobe that drive the downstream enabled toggle flip-flops (d <= toggle_req[ch], enable <= sample_en). It also reports which channel detected a ping first.

Parameters:
NUM_CH, 4, number of hydrophone channels
FILT_CYC, 8, consecutive synchronised-high samples required to qualify a ping (>=1)
HOLDOFF_CYC, 1000, cycles a channel ignores its input after a qualified ping (>=1)
PRESCALE, 50, period of sample_en in clk cycles (>=2)
CNT_W, 16, width of the internal filter, holdoff and prescale counters (must hold max of the three)

Ports:
clk  in  1  system clock; the only clock
reset  in  1  asynchronous, active-high reset
hp_in  in  NUM_CH  raw asynchronous comparator outputs, one bit per channel
arm  in  1  level; while high, idle channels may start qualification
clear  in  1  synchronous clear of all channel state and flags
sample_en  out  1  one-cycle strobe every PRESCALE cycles; drives downstream FF enable
toggle_req  out  NUM_CH  held request per channel; drives downstream FF d
detected  out  NUM_CH  sticky: channel has qualified at least one ping since clear
overrun  out  NUM_CH  sticky: channel qualified again while its toggle_req was still pending
first_valid  out  1  sticky: first_ch holds a valid channel index
first_ch  out  clog2(NUM_CH)  index of the first channel to qualify

Behaviour:
- One clock clk; reset is asynchronous and active-high, named reset.
- Reset: all outputs 0, all channels in IDLE, prescaler count 0, synchronisers 0.
- Synchronisation: each hp_in bit passes through a 2-flop synchroniser giving s[ch]. s_prev[ch] is s delayed one cycle.
- Per-channel FSM:
  - IDLE: if arm=1 and s=1 and s_prev=0, go to QUAL with cnt=1; otherwise stay.
  - QUAL: if s=0, go to IDLE. If s=1 and cnt=FILT_CYC, go to FIRE. Otherwise cnt+1.
  - FIRE (1 cycle): set toggle_req[ch]. Set detected[ch]. Set overrun[ch] if toggle_req[ch] was already 1. Load holdoff cnt=1 and go to HOLDOFF.
  - HOLDOFF: ignore s; cnt+1; when cnt=HOLDOFF_CYC, go to IDLE.
- Latency: hp_in held high from cycle 0 gives toggle_req high at cycle FILT_CYC+3, with ±1 cycle of synchroniser uncertainty.
- A high pulse shorter than FILT_CYC synchronised samples produces nothing. A level already high when arm rises does not qualify, because a rising edge is required.
- arm low blocks only the IDLE->QUAL transition. QUAL and HOLDOFF run to completion.
- Prescaler: free-running counter 0..PRESCALE-1. sample_en=1 in the cycle the count equals PRESCALE-1. clear does not affect the prescaler.
- toggle_req handshake:
  - Set on FIRE.
  - Cleared on the clock edge that ends a cycle where sample_en=1 and toggle_req=1, so the downstream FF toggles exactly once per request.
  - If FIRE and consumption coincide in the same cycle, the set wins: toggle_req stays 1 and overrun is set.
- First arrival: on the first cycle any channel is in FIRE while first_valid=0, latch first_ch and set first_valid.
  - If several channels are in FIRE in that cycle, the lowest index wins.
  - Later FIREs do not change first_ch until clear.
- clear, with priority over all set conditions in the same cycle:
  - All FSMs go to IDLE and counters to 0.
  - toggle_req, detected, overrun and first_valid go to 0; first_ch goes to 0.
- Reset asserted mid-qualification or mid-holdoff: immediate return to the reset state; no partial request survives.

Decomposition:
- Shared package sonar_pkg: channel FSM state encoding (IDLE, QUAL, FIRE, HOLDOFF), CNT_W default, and a clog2 helper/constant for the first_ch width.
- Sub-module sonar_channel_filter: synchroniser, edge detect, FSM, counters and toggle_req/detected/overrun for one channel. It is instantiated NUM_CH times by generate.
- The top level holds the prescaler and the first-arrival latch.

Test Plan:
- Reset: drive hp_in=4'b1111 and arm=1 during reset -> all outputs 0; no FIRE after reset release because no rising edge occurs.
- Qualification: FILT_CYC=8, ch2 rises and is held high -> toggle_req[2] rises at cycle 11 (±1), detected[2]=1, first_valid=1, first_ch=2. A 5-cycle pulse on ch0 -> no outputs.
- Handshake: PRESCALE=50, ch1 fires -> toggle_req[1] stays high until the first sample_en, then drops the next cycle. The downstream model toggles exactly once.
- Holdoff and overrun:
  - HOLDOFF_CYC=20, PRESCALE=50: ch3 is pulsed at 0 and 30 cycles -> the second FIRE finds toggle_req[3] pending, so overrun[3]=1.
  - A pulse inside the holdoff window is ignored.
- Simultaneous: ch1 and ch3 rise on the same edge -> first_ch=1 and both toggle_req bits set. Then assert clear coincident with a new FIRE on ch0 -> all flags 0 the next cycle.
- arm gating: arm=0 while ch0 rises -> no detection. Set arm=1 while ch0 stays high -> still none. Drop ch0 and raise it again -> detection.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared definitions for the SONAR ping qualifier: channel FSM encoding,
// counter width default and the first-channel index width helper.
package sonar_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_QUAL = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Index width that stays at least one bit for a single-channel build.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sonar_ping_qualifier_if.sv
// Control/status bundle of the ping qualifier: raw hydrophone inputs and
// controls in, toggle requests, strobe and detection flags out.
interface sonar_ping_qualifier_if
  import sonar_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int FCH_W  = ch_w(NUM_CH)
);
  logic [NUM_CH-1:0] hp_in;
  logic              arm;
  logic              clear;
  logic              sample_en;
  logic [NUM_CH-1:0] toggle_req;
  logic [NUM_CH-1:0] detected;
  logic [NUM_CH-1:0] overrun;
  logic              first_valid;
  logic [FCH_W-1:0]  first_ch;

  modport master (
    output hp_in, arm, clear,
    input  sample_en, toggle_req, detected, overrun, first_valid, first_ch
  );

  modport slave (
    input  hp_in, arm, clear,
    output sample_en, toggle_req, detected, overrun, first_valid, first_ch
  );
endinterface

// File: rtl/sonar_channel_filter.sv
// One hydrophone channel: 2-flop synchroniser, rising-edge detect, glitch
// filter / holdoff FSM and the held toggle request with its sticky flags.
module sonar_channel_filter
  import sonar_pkg::*;
#(
  parameter int FILT_CYC    = 8,
  parameter int HOLDOFF_CYC = 1000,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic hp,
  input  logic arm,
  input  logic clear,
  input  logic sample_en,
  output logic fire,
  output logic toggle_req,
  output logic detected,
  output logic overrun
);
  localparam logic [CNT_W-1:0] FILT_N = CNT_W'(FILT_CYC);
  localparam logic [CNT_W-1:0] HOLD_N = CNT_W'(HOLDOFF_CYC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic             sync1_q, sync1_d, s_q, s_d, s_prev_q, s_prev_d;
  logic [2:0]       vld_pipe_q, vld_pipe_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             toggle_q, toggle_d, det_q, det_d, ovr_q, ovr_d;

  always_comb begin
    sync1_d    = hp;
    s_d        = sync1_q;
    s_prev_d   = s_q;
    // Edges are only trusted once the sync pipe has filled after reset, so a
    // level held through reset never looks like a fresh rising edge.
    vld_pipe_d = {vld_pipe_q[1:0], 1'b1};
    state_d    = state_q;
    cnt_d      = cnt_q;
    toggle_d   = toggle_q;
    det_d      = det_q;
    ovr_d      = ovr_q;

    if (sample_en && toggle_q) toggle_d = 1'b0;

    case (state_q)
      ST_IDLE: if (arm && s_q && !s_prev_q && vld_pipe_q[2]) begin
        state_d = ST_QUAL;
        cnt_d   = ONE;
      end
      ST_QUAL: begin
        if (!s_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == FILT_N) state_d = ST_FIRE;
        else cnt_d = cnt_q + ONE;
      end
      ST_FIRE: begin
        // Set overrides a coincident consumption.
        toggle_d = 1'b1;
        det_d    = 1'b1;
        if (toggle_q) ovr_d = 1'b1;
        cnt_d    = ONE;
        state_d  = ST_HOLD;
      end
      default: begin
        if (cnt_q == HOLD_N) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + ONE;
      end
    endcase

    if (clear) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      toggle_d = 1'b0;
      det_d    = 1'b0;
      ovr_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      s_q        <= 1'b0;
      s_prev_q   <= 1'b0;
      vld_pipe_q <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      toggle_q   <= 1'b0;
      det_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      s_q        <= s_d;
      s_prev_q   <= s_prev_d;
      vld_pipe_q <= vld_pipe_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      toggle_q   <= toggle_d;
      det_q      <= det_d;
      ovr_q      <= ovr_d;
    end
  end

  assign fire       = (state_q == ST_FIRE);
  assign toggle_req = toggle_q;
  assign detected   = det_q;
  assign overrun    = ovr_q;
endmodule

// File: rtl/sonar_ping_qualifier.sv
// SONAR front end: per-channel ping qualification, the sample_en prescaler
// feeding the downstream toggle flops, and the first-arrival latch.
module sonar_ping_qualifier
  import sonar_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int FILT_CYC    = 8,
  parameter int HOLDOFF_CYC = 1000,
  parameter int PRESCALE    = 50,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic clk,
  input logic reset,
  sonar_ping_qualifier_if.slave bus
);
  localparam int               FCH_W   = ch_w(NUM_CH);
  localparam logic [CNT_W-1:0] PSC_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0]  psc_q, psc_d;
  logic              sample_en;
  logic [NUM_CH-1:0] fire, toggle_req, detected, overrun;
  logic              first_valid_q, first_valid_d;
  logic [FCH_W-1:0]  first_ch_q, first_ch_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sonar_channel_filter #(
      .FILT_CYC   (FILT_CYC),
      .HOLDOFF_CYC(HOLDOFF_CYC),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .hp        (bus.hp_in[g]),
      .arm       (bus.arm),
      .clear     (bus.clear),
      .sample_en (sample_en),
      .fire      (fire[g]),
      .toggle_req(toggle_req[g]),
      .detected  (detected[g]),
      .overrun   (overrun[g])
    );
  end

  assign sample_en = (psc_q == PSC_MAX);

  always_comb begin
    psc_d         = sample_en ? '0 : psc_q + CNT_W'(1);
    first_valid_d = first_valid_q;
    first_ch_d    = first_ch_q;
    // Downward scan so the lowest simultaneously firing channel wins.
    if (!first_valid_q && |fire) begin
      first_valid_d = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (fire[i]) first_ch_d = FCH_W'(i);
    end
    if (bus.clear) begin
      first_valid_d = 1'b0;
      first_ch_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_q         <= '0;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
    end else begin
      psc_q         <= psc_d;
      first_valid_q <= first_valid_d;
      first_ch_q    <= first_ch_d;
    end
  end

  assign bus.sample_en   = sample_en;
  assign bus.toggle_req  = toggle_req;
  assign bus.detected    = detected;
  assign bus.overrun     = overrun;
  assign bus.first_valid = first_valid_q;
  assign bus.first_ch    = first_ch_q;
endmodule
